// File: rtl/axis_frame_pad_trunc.sv
// AXI4-Stream frame length conditioner: zero-pads short frames up to MIN_LEN beats,
// cuts long frames at MAX_LEN beats, and reports one status pulse per frame.
module axis_frame_pad_trunc #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int LEN_WIDTH  = 16,
    parameter int MIN_LEN    = 60,
    parameter int MAX_LEN    = 1518,
    parameter int PAD_VALUE  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  status_valid,
    output logic [LEN_WIDTH-1:0]  status_frame_len,
    output logic                  status_padded,
    output logic                  status_truncated
);

    localparam logic [1:0] ST_PASS = 2'd0;
    localparam logic [1:0] ST_PAD  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [LEN_WIDTH-1:0]  MIN_LEN_C = LEN_WIDTH'(MIN_LEN);
    localparam logic [LEN_WIDTH-1:0]  MAX_LEN_C = LEN_WIDTH'(MAX_LEN);
    localparam logic [DATA_WIDTH-1:0] PAD_C     = DATA_WIDTH'(PAD_VALUE);

    logic [1:0]            state_q, state_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]  n_s;
    logic                  run_q;
    logic                  load_en_s;
    logic                  ready_s;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [USER_WIDTH-1:0] tuser_q, tuser_d;
    logic [USER_WIDTH-1:0] tuser_lat_q, tuser_lat_d;
    logic                  st_valid_q, st_valid_d;
    logic [LEN_WIDTH-1:0]  st_len_q, st_len_d;
    logic                  st_pad_q, st_pad_d;
    logic                  st_trunc_q, st_trunc_d;

    assign s_axis_tready    = ready_s;
    assign m_axis_tdata     = tdata_q;
    assign m_axis_tvalid    = tvalid_q;
    assign m_axis_tlast     = tlast_q;
    assign m_axis_tuser     = tuser_q;
    assign status_valid     = st_valid_q;
    assign status_frame_len = st_len_q;
    assign status_padded    = st_pad_q;
    assign status_truncated = st_trunc_q;

    // Next-state, output-register and status computation for all three states.
    always_comb begin
        load_en_s   = m_axis_tready || !tvalid_q;
        n_s         = cnt_q + LEN_WIDTH'(1);
        state_d     = state_q;
        cnt_d       = cnt_q;
        tdata_d     = tdata_q;
        tlast_d     = tlast_q;
        tuser_d     = tuser_q;
        tvalid_d    = load_en_s ? 1'b0 : tvalid_q;
        tuser_lat_d = tuser_lat_q;
        st_valid_d  = 1'b0;
        st_len_d    = st_len_q;
        st_pad_d    = st_pad_q;
        st_trunc_d  = st_trunc_q;
        ready_s     = 1'b0;

        case (state_q)
            ST_PASS: begin
                // run_q keeps tready low while the block is held in reset.
                ready_s = run_q && load_en_s;
                if (ready_s && s_axis_tvalid) begin
                    tvalid_d = 1'b1;
                    tdata_d  = s_axis_tdata;
                    tuser_d  = s_axis_tuser;
                    tlast_d  = 1'b0;
                    cnt_d    = n_s;
                    if (s_axis_tlast) begin
                        if (n_s >= MIN_LEN_C) begin
                            tlast_d    = 1'b1;
                            st_valid_d = 1'b1;
                            st_len_d   = n_s;
                            st_pad_d   = 1'b0;
                            st_trunc_d = 1'b0;
                            cnt_d      = '0;
                        end else begin
                            tuser_d     = '0;
                            tuser_lat_d = s_axis_tuser;
                            state_d     = ST_PAD;
                        end
                    end else if (n_s == MAX_LEN_C) begin
                        tlast_d = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        tlast_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_PAD: begin
                ready_s = 1'b0;
                if (load_en_s) begin
                    tvalid_d = 1'b1;
                    tdata_d  = PAD_C;
                    tuser_d  = '0;
                    tlast_d  = 1'b0;
                    cnt_d    = n_s;
                    if (n_s == MIN_LEN_C) begin
                        tlast_d    = 1'b1;
                        tuser_d    = tuser_lat_q;
                        st_valid_d = 1'b1;
                        st_len_d   = MIN_LEN_C;
                        st_pad_d   = 1'b1;
                        st_trunc_d = 1'b0;
                        cnt_d      = '0;
                        state_d    = ST_PASS;
                    end else begin
                        state_d = ST_PAD;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DROP: begin
                // Discard independently of the output register so a stall cannot block it.
                ready_s = run_q;
                if (ready_s && s_axis_tvalid && s_axis_tlast) begin
                    st_valid_d = 1'b1;
                    st_len_d   = MAX_LEN_C;
                    st_pad_d   = 1'b0;
                    st_trunc_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_PASS;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_PASS;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, output register and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PASS;
            cnt_q       <= '0;
            run_q       <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= '0;
            tuser_lat_q <= '0;
            st_valid_q  <= 1'b0;
            st_len_q    <= '0;
            st_pad_q    <= 1'b0;
            st_trunc_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_q       <= 1'b1;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            tuser_lat_q <= tuser_lat_d;
            st_valid_q  <= st_valid_d;
            st_len_q    <= st_len_d;
            st_pad_q    <= st_pad_d;
            st_trunc_q  <= st_trunc_d;
        end
    end

endmodule

// File: doc/axis_frame_pad_trunc.md
Name: axis_frame_pad_trunc

Overview:
AXI4-Stream frame length conditioner that sits directly downstream of the AXI-Stream FIFO and consumes its m_axis output.
- Frames shorter than MIN_LEN beats are zero-padded up to MIN_LEN.
- Frames longer than MAX_LEN beats are cut at MAX_LEN; the remaining input beats are discarded.
- One status pulse is reported per frame.
- One output register stage; full throughput when not padding.

Parameters:
DATA_WIDTH, 8, tdata width.
USER_WIDTH, 1, tuser width.
LEN_WIDTH, 16, width of beat counter and status length.
MIN_LEN, 60, minimum output frame length in beats. Must satisfy 1 <= MIN_LEN <= MAX_LEN.
MAX_LEN, 1518, maximum output frame length in beats. Must satisfy MAX_LEN < 2**LEN_WIDTH.
PAD_VALUE, 0, tdata value of inserted pad beats.

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
s_axis_tdata  in  DATA_WIDTH  input data
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input end of frame
s_axis_tuser  in  USER_WIDTH  input user (bad-frame flag)
m_axis_tdata  out  DATA_WIDTH  output data
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output end of frame
m_axis_tuser  out  USER_WIDTH  output user
status_valid  out  1  one-cycle pulse per completed frame
status_frame_len  out  LEN_WIDTH  output frame length in beats
status_padded  out  1  frame was padded
status_truncated  out  1  frame was truncated

Behaviour:
- Reset (rst_n low, async):
  - m_axis_tvalid=0, s_axis_tready=0, all status outputs=0.
  - State=PASS, beat counter cnt=0.
  - m_axis_tdata/tlast/tuser register contents are don't-care.
  - Reset asserted mid-frame abandons the frame; no status pulse is produced.
- Output register: load_en = m_axis_tready || !m_axis_tvalid. Latency from input acceptance to m_axis_tvalid is 1 cycle.
- State PASS:
  - s_axis_tready = load_en.
  - Each accepted beat is copied to the output register and cnt increments. Let n = cnt+1.
  - tlast=1, n >= MIN_LEN: forward with tlast=1; status pulse with len=n; cnt->0; stay in PASS.
  - tlast=1, n < MIN_LEN: forward with tlast=0; latch tuser; go to PAD.
  - tlast=0, n == MAX_LEN: forward with tlast=1 and tuser forced to input tuser; go to DROP.
  - A frame of exactly MAX_LEN beats with tlast on beat MAX_LEN is not truncated.
- State PAD:
  - s_axis_tready=0.
  - On each load_en, emit PAD_VALUE with tuser=0 and cnt++.
  - The beat that brings cnt to MIN_LEN has tlast=1 and tuser=latched tuser. That beat produces the status pulse with padded=1, len=MIN_LEN; cnt->0; go to PASS.
- State DROP:
  - s_axis_tready=1; accepted beats are discarded.
  - On the accepted tlast: status pulse with truncated=1, len=MAX_LEN; cnt->0; go to PASS.
  - Downstream stall does not stall DROP.
- Status outputs:
  - status_valid is registered, high for exactly one cycle, in the cycle after the triggering event.
  - status_frame_len, status_padded and status_truncated are valid only while status_valid=1 and are held otherwise.
- Single-beat frame (tlast on the first beat) with MIN_LEN=1: passes unchanged.
- cnt never exceeds MAX_LEN; no wrap-around.
- Back-to-back frames in PASS have no bubble.
- A new frame is accepted in the cycle after the final pad beat loads.

Test Plan:
1. MIN_LEN=4, MAX_LEN=8, m_axis_tready=1; send 5-beat frame 0x01..0x05 -> same 5 beats out, tlast on 0x05, 1-cycle latency; status len=5, padded=0, truncated=0.
2. Send 2-beat frame 0xA1, 0xA2 with tuser=1 on the last beat -> output A1, A2, 00, 00 with tlast and tuser=1 only on beat 4; s_axis_tready low for 2 cycles; status len=4, padded=1.
3. Send 11-beat frame 0x10..0x1A -> output 0x10..0x17, tlast on 0x17; beats 0x18..0x1A are accepted and dropped; status len=8, truncated=1, pulsed after 0x1A is accepted.
4. Exactly 8-beat frame ending in tlast -> 8 beats out, truncated=0; next frame starts with no bubble.
5. Random m_axis_tready (50%) over 200 mixed-length frames -> no beat lost or duplicated versus a reference model; m_axis_tvalid, tdata and tlast stay stable while stalled.
6. Deassert rst_n during a PAD sequence -> m_axis_tvalid=0 immediately (async); no status pulse; after release the next 5-beat frame passes normally.
